q_mux_arbiter: RTL and testbench



---
 rtl/q_mux_pkg.sv | 19 +
 rtl/q_mux_arbiter_rr_pick.sv | 34 +++
 rtl/q_mux_arbiter.sv | 83 ++++++++
 tb/tb_q_mux_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/q_mux_pkg.sv
// rtl/q_mux_pkg.sv - shared constants, state encoding and one-hot helper for the q_mux arbiter
package q_mux_pkg;

    localparam int N_REQ  = 16;
    localparam int SEL_W  = 4;
    localparam int DATA_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/q_mux_arbiter_rr_pick.sv
// rtl/q_mux_arbiter_rr_pick.sv - rotating priority encoder scanning from ptr+1 with optional ptr mask
module rr_pick
    import q_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mask_en,
    output logic             any,
    output logic [SEL_W-1:0] winner
);

    logic [N_REQ-1:0] masked;
    logic [SEL_W-1:0] idx;

    always_comb begin
        masked = req;
        if (mask_en) begin
            masked[ptr] = 1'b0;
        end
        any    = 1'b0;
        winner = ptr;
        idx    = ptr;
        // Walk offsets from farthest to nearest so the nearest set request wins;
        // offset 16 wraps to ptr itself, the lowest priority.
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ptr + SEL_W'(i);
            if (masked[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/q_mux_arbiter.sv
// rtl/q_mux_arbiter.sv - round-robin arbiter driving an external 16:1 mux select and registering its word
module q_mux_arbiter
    import q_mux_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] mux_dout,
    output logic [SEL_W-1:0]  sel,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic             pick_any;
    logic [SEL_W-1:0] pick_winner;
    logic             mask_en;
    logic             handshake;

    // The served requester still holds req during its handshake cycle, so hide it.
    assign mask_en   = (state == ST_HOLD);
    assign handshake = (state == ST_HOLD) && out_ready;
    assign ack       = handshake ? onehot(ptr) : '0;
    assign busy      = (state != ST_IDLE);

    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (ptr),
        .mask_en (mask_en),
        .any     (pick_any),
        .winner  (pick_winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= SEL_W'(N_REQ - 1);
            sel       <= '0;
            gnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state <= ST_LOAD;
                        sel   <= pick_winner;
                        gnt   <= onehot(pick_winner);
                        ptr   <= pick_winner;
                    end
                end
                ST_LOAD: begin
                    out_data  <= mux_dout;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pick_any) begin
                            state <= ST_LOAD;
                            sel   <= pick_winner;
                            gnt   <= onehot(pick_winner);
                            ptr   <= pick_winner;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_mux_arbiter.sv
// tb/tb_q_mux_arbiter.sv - directed self-checking bench for q_mux_arbiter
module tb_q_mux_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] mux_dout;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic [15:0] ack;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [15:0] mux_tab [16];
    int vectors = 0;
    int miscompares = 0;

    assign mux_dout = mux_tab[sel];

    always #5 clk = ~clk;

    q_mux_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mux_dout  (mux_dout),
        .sel       (sel),
        .gnt       (gnt),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mux_tab[i] = 16'(i * 16'h0101);
        mux_tab[0] = 16'h00A0;
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // single request, immediate accept
        tick();
        req = 16'h0001; out_ready = 1'b1; settle();
        chk("t1_c0_busy", 32'(busy), 32'h0);
        tick();
        chk("t1_c1_sel", 32'(sel), 32'h0);
        chk("t1_c1_gnt", 32'(gnt), 32'h0001);
        chk("t1_c1_valid", 32'(out_valid), 32'h0);
        chk("t1_c1_ack", 32'(ack), 32'h0);
        tick();
        chk("t1_c2_valid", 32'(out_valid), 32'h1);
        chk("t1_c2_data", 32'(out_data), 32'h00A0);
        chk("t1_c2_ack", 32'(ack), 32'h0001);
        req = 16'h0000;
        tick();
        chk("t1_c3_busy", 32'(busy), 32'h0);
        chk("t1_c3_gnt", 32'(gnt), 32'h0);
        chk("t1_c3_valid", 32'(out_valid), 32'h0);

        // all requesting from fresh reset: order 0..15,0
        mux_tab[0] = 16'h0000;
        rst_n = 1'b0; settle(); rst_n = 1'b1;
        tick();
        req = 16'hFFFF; out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk($sformatf("t2_sel_%0d", k), 32'(sel), 32'(k % 16));
            chk($sformatf("t2_gnt_%0d", k), 32'(gnt), 32'(16'h1 << (k % 16)));
            chk($sformatf("t2_lack_%0d", k), 32'(ack), 32'h0);
            tick();
            if (k == 16) req = 16'h0000;
            settle();
            chk($sformatf("t2_valid_%0d", k), 32'(out_valid), 32'h1);
            chk($sformatf("t2_data_%0d", k), 32'(out_data), 32'((k % 16) * 16'h0101));
            chk($sformatf("t2_ack_%0d", k), 32'(ack), 32'(16'h1 << (k % 16)));
        end
        tick();
        chk("t2_idle", 32'(busy), 32'h0);

        // ptr=3 then req 0 and 3: wraps to 0, 3 masked in its own handshake
        req = 16'h0008;
        tick();
        chk("t3_sel3", 32'(sel), 32'h3);
        tick();
        req = 16'h0009; settle();
        chk("t3_ack3", 32'(ack), 32'h0008);
        tick();
        chk("t3_sel0", 32'(sel), 32'h0);
        chk("t3_gnt0", 32'(gnt), 32'h0001);
        tick();
        chk("t3_ack0", 32'(ack), 32'h0001);
        chk("t3_data0", 32'(out_data), 32'h0000);
        tick();
        chk("t3_sel3b", 32'(sel), 32'h3);
        tick();
        req = 16'h0000; settle();
        chk("t3_ack3b", 32'(ack), 32'h0008);
        chk("t3_data3", 32'(out_data), 32'h0303);
        tick();

        // stall in HOLD while the mux output moves
        req = 16'h0040; out_ready = 1'b0;
        tick();
        chk("t4_sel6", 32'(sel), 32'h6);
        tick();
        mux_tab[6] = 16'hBEEF;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("t4_data_%0d", s), 32'(out_data), 32'h0606);
            chk($sformatf("t4_sel_%0d", s), 32'(sel), 32'h6);
            chk($sformatf("t4_gnt_%0d", s), 32'(gnt), 32'h0040);
            chk($sformatf("t4_ack_%0d", s), 32'(ack), 32'h0);
            chk($sformatf("t4_valid_%0d", s), 32'(out_valid), 32'h1);
            tick();
        end
        out_ready = 1'b1; req = 16'h0000; settle();
        chk("t4_ack", 32'(ack), 32'h0040);
        chk("t4_data", 32'(out_data), 32'h0606);
        tick();
        chk("t4_idle", 32'(busy), 32'h0);
        mux_tab[6] = 16'h0606;

        // request dropped during LOAD still completes
        req = 16'h0020;
        tick();
        chk("t5_sel5", 32'(sel), 32'h5);
        req = 16'h0000;
        tick();
        chk("t5_data", 32'(out_data), 32'h0505);
        chk("t5_ack", 32'(ack), 32'h0020);
        tick();
        chk("t5_idle", 32'(busy), 32'h0);
        chk("t5_gnt", 32'(gnt), 32'h0);

        // reset during HOLD, then first grant from index 0
        req = 16'h0104; out_ready = 1'b0;
        tick();
        chk("t6_gnt8", 32'(gnt), 32'h0100);
        tick();
        chk("t6_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1; rst_n = 1'b0; settle();
        chk("t6_rst_valid", 32'(out_valid), 32'h0);
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_ack", 32'(ack), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_gnt2", 32'(gnt), 32'h0004);
        chk("t6_sel2", 32'(sel), 32'h2);
        tick();
        req = 16'h0000; settle();
        chk("t6_ack2", 32'(ack), 32'h0004);
        chk("t6_data2", 32'(out_data), 32'h0202);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
